// File: rtl/bispectrum_seg_accumulator.sv
// Averages each bispectrum bin over 2^LOG2_NSEG segments; averaged bins stream out during the last segment.
// Optional build macro BISPEC_ACC_ROUND_EN selects round-half-up averaging instead of floor.
module bispectrum_seg_accumulator #(
  parameter int DATA_W    = 16,
  parameter int NBINS     = 64,
  parameter int LOG2_NSEG = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  b_r,
  input  logic signed [DATA_W-1:0]  b_i,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_r,
  output logic signed [DATA_W-1:0]  out_i,
  output logic [$clog2(NBINS)-1:0]  out_bin,
  output logic                      busy,
  output logic                      done,
  output logic                      drop_err
);

  localparam int BIN_W = $clog2(NBINS);
  localparam int ACC_W = DATA_W + LOG2_NSEG;
  localparam int NSEG  = 1 << LOG2_NSEG;
  localparam logic [BIN_W-1:0]     LAST_BIN = BIN_W'(NBINS - 1);
  localparam logic [LOG2_NSEG-1:0] LAST_SEG = LOG2_NSEG'(NSEG - 1);
  localparam logic [BIN_W-1:0]     BIN_ONE  = BIN_W'(1);
  localparam logic [LOG2_NSEG-1:0] SEG_ONE  = LOG2_NSEG'(1);

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [BIN_W-1:0]         bin_cnt_q, bin_cnt_d;
  logic [LOG2_NSEG-1:0]     seg_cnt_q, seg_cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic                     done_q, done_d;
  logic                     drop_err_q, drop_err_d;
  logic signed [DATA_W-1:0] out_r_q, out_r_d;
  logic signed [DATA_W-1:0] out_i_q, out_i_d;
  logic [BIN_W-1:0]         out_bin_q, out_bin_d;

  // Accumulator RAM is deliberately left unreset: segment 0 overwrites every bin.
  logic signed [ACC_W-1:0]  acc_r_mem [NBINS];
  logic signed [ACC_W-1:0]  acc_i_mem [NBINS];

  logic                     acc_we_s;
  logic signed [ACC_W-1:0]  b_r_ext_s, b_i_ext_s;
  logic signed [ACC_W-1:0]  sum_r_s, sum_i_s;
  logic signed [ACC_W-1:0]  wr_r_s, wr_i_s;
  logic signed [DATA_W-1:0] avg_r_s, avg_i_s;

  assign b_r_ext_s = {{LOG2_NSEG{b_r[DATA_W-1]}}, b_r};
  assign b_i_ext_s = {{LOG2_NSEG{b_i[DATA_W-1]}}, b_i};
  assign sum_r_s   = acc_r_mem[bin_cnt_q] + b_r_ext_s;
  assign sum_i_s   = acc_i_mem[bin_cnt_q] + b_i_ext_s;
  assign wr_r_s    = (seg_cnt_q == '0) ? b_r_ext_s : sum_r_s;
  assign wr_i_s    = (seg_cnt_q == '0) ? b_i_ext_s : sum_i_s;

`ifdef BISPEC_ACC_ROUND_EN
  localparam logic signed [ACC_W:0] RND_C = (ACC_W + 1)'(2 ** (LOG2_NSEG - 1));
  logic signed [ACC_W:0] rsum_r_s, rsum_i_s;
  assign rsum_r_s = {sum_r_s[ACC_W-1], sum_r_s} + RND_C;
  assign rsum_i_s = {sum_i_s[ACC_W-1], sum_i_s} + RND_C;
  // The mean of NSEG DATA_W samples always fits DATA_W, so the top bits are pure sign.
  assign avg_r_s  = rsum_r_s[ACC_W-1:LOG2_NSEG];
  assign avg_i_s  = rsum_i_s[ACC_W-1:LOG2_NSEG];
`else
  assign avg_r_s  = sum_r_s[ACC_W-1:LOG2_NSEG];
  assign avg_i_s  = sum_i_s[ACC_W-1:LOG2_NSEG];
`endif

  // Next-state and output decode; start always beats a same-cycle sample.
  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    seg_cnt_d   = seg_cnt_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    drop_err_d  = drop_err_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_bin_d   = out_bin_q;
    acc_we_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCUM;
          bin_cnt_d  = '0;
          seg_cnt_d  = '0;
          drop_err_d = 1'b0;
        end else if (in_valid) begin
          drop_err_d = 1'b1;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (start) begin
          bin_cnt_d  = '0;
          seg_cnt_d  = '0;
          drop_err_d = 1'b0;
        end else if (in_valid) begin
          if (seg_cnt_q == LAST_SEG) begin
            out_valid_d = 1'b1;
            out_r_d     = avg_r_s;
            out_i_d     = avg_i_s;
            out_bin_d   = bin_cnt_q;
          end else begin
            acc_we_s    = 1'b1;
          end
          if (bin_cnt_q == LAST_BIN) begin
            bin_cnt_d = '0;
            seg_cnt_d = seg_cnt_q + SEG_ONE;
            if (seg_cnt_q == LAST_SEG) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              done_d  = 1'b0;
            end
          end else begin
            bin_cnt_d = bin_cnt_q + BIN_ONE;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_cnt_q   <= '0;
      seg_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      drop_err_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_bin_q   <= '0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      seg_cnt_q   <= seg_cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      drop_err_q  <= drop_err_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_bin_q   <= out_bin_d;
    end
  end

  // Accumulator RAM write port.
  always_ff @(posedge clk) begin
    if (acc_we_s) begin
      acc_r_mem[bin_cnt_q] <= wr_r_s;
      acc_i_mem[bin_cnt_q] <= wr_i_s;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_bin   = out_bin_q;
  assign busy      = (state_q == S_ACCUM);
  assign done      = done_q;
  assign drop_err  = drop_err_q;

endmodule
